// File: rtl/kernel_loader_pkg.sv
// Shared constants, loader state encoding and beat-count helper for the kernel loader.
package kernel_loader_pkg;

  localparam int DRAM_DATA_BITS = 512;
  localparam int DRAM_ADDR_BITS = 29;
  localparam int KER_NUM        = 3;
  localparam int KER_WIDTH_MAX  = 75;
  localparam int KER_HEIGHT_MAX = 1920;

  localparam int ROW_WIDTH     = KER_WIDTH_MAX;
  localparam int ROW_ADDR_BITS = $clog2(KER_HEIGHT_MAX);
  localparam int ROW_CNT_BITS  = ROW_ADDR_BITS + 1;
  localparam int KER_SEL_BITS  = $clog2(KER_NUM);
  localparam int ACC_BITS      = ROW_WIDTH - 1 + DRAM_DATA_BITS;
  localparam int ACC_CNT_BITS  = $clog2(ACC_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_FIN
  } loader_state_e;

  // Number of DRAM beats needed to hold a given number of packed rows.
  function automatic logic [ROW_CNT_BITS-1:0] beats_for_rows(input logic [ROW_CNT_BITS-1:0] rows);
    logic [31:0] bits;
    bits = 32'(rows) * 32'(ROW_WIDTH) + 32'(DRAM_DATA_BITS - 1);
    return ROW_CNT_BITS'(bits / 32'(DRAM_DATA_BITS));
  endfunction

endpackage

// File: rtl/kernel_unpacker.sv
// Bit accumulator that appends DRAM beats above the residual bits and pops rows from the LSBs.
module kernel_unpacker
  import kernel_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic [DRAM_DATA_BITS-1:0] beat_i,
  input  logic                      pop_i,
  output logic [ROW_WIDTH-1:0]      row_o,
  output logic [ACC_CNT_BITS-1:0]   acc_cnt_o
);

  logic [ACC_BITS-1:0]     acc_q, acc_d;
  logic [ACC_CNT_BITS-1:0] cnt_q, cnt_d;

  // Next accumulator contents: clear, append a beat at the fill level, or drop one row.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      // Stale bits above the fill level are masked so leftovers never leak into new rows.
      acc_d = (acc_q & ~({ACC_BITS{1'b1}} << cnt_q))
            | ({{(ACC_BITS-DRAM_DATA_BITS){1'b0}}, beat_i} << cnt_q);
      cnt_d = cnt_q + ACC_CNT_BITS'(DRAM_DATA_BITS);
    end else if (pop_i) begin
      acc_d = acc_q >> ROW_WIDTH;
      cnt_d = cnt_q - ACC_CNT_BITS'(ROW_WIDTH);
    end
  end

  // Accumulator and fill-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign row_o     = acc_q[ROW_WIDTH-1:0];
  assign acc_cnt_o = cnt_q;

endmodule

// File: rtl/kernel_loader.sv
// Loads one kernel bank: fetches DRAM beats one at a time and writes packed 75-bit rows.
//
//   state | meaning
//   IDLE  | waiting for start; parameters latched on start
//   REQ   | read request held until DRAM acknowledges
//   WAIT  | one request outstanding, waiting for its beat
//   DRAIN | one row written per cycle while a whole row is buffered
//   FIN   | load complete, done pulse follows
module kernel_loader
  import kernel_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KER_SEL_BITS-1:0]   ker_sel,
  input  logic [DRAM_ADDR_BITS-1:0] base_addr,
  input  logic [ROW_ADDR_BITS:0]    row_count,
  output logic                      busy,
  output logic                      done,
  output logic                      dram_rd_req,
  output logic [DRAM_ADDR_BITS-1:0] dram_rd_addr,
  input  logic                      dram_rd_ack,
  input  logic                      dram_rd_valid,
  input  logic [DRAM_DATA_BITS-1:0] dram_rd_data,
  output logic                      ker_wr_en,
  output logic [KER_SEL_BITS-1:0]   ker_wr_sel,
  output logic [ROW_ADDR_BITS-1:0]  ker_wr_addr,
  output logic [ROW_WIDTH-1:0]      ker_wr_data
);

  localparam logic [ACC_CNT_BITS-1:0] ROW_W_C  = ACC_CNT_BITS'(ROW_WIDTH);
  localparam logic [ACC_CNT_BITS-1:0] ROW_W2_C = ACC_CNT_BITS'(2 * ROW_WIDTH);

  loader_state_e             state_q;
  logic [KER_SEL_BITS-1:0]   sel_q;
  logic [ROW_CNT_BITS-1:0]   count_q;
  logic [ROW_CNT_BITS-1:0]   rows_q;
  logic [ROW_CNT_BITS-1:0]   rows_next;
  logic                      busy_q, done_q, req_q, wr_en_q;
  logic [DRAM_ADDR_BITS-1:0] addr_q;
  logic [KER_SEL_BITS-1:0]   wr_sel_q;
  logic [ROW_ADDR_BITS-1:0]  wr_addr_q;
  logic [ROW_WIDTH-1:0]      wr_data_q;

  logic                      unp_clear, unp_load, unp_pop;
  logic [ROW_WIDTH-1:0]      unp_row;
  logic [ACC_CNT_BITS-1:0]   acc_cnt;

  assign unp_clear = (state_q == ST_IDLE) && start;
  assign unp_load  = (state_q == ST_WAIT) && dram_rd_valid;
  assign unp_pop   = (state_q == ST_DRAIN) && (acc_cnt >= ROW_W_C);
  assign rows_next = rows_q + 1'b1;

  kernel_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (unp_clear),
    .load_i    (unp_load),
    .beat_i    (dram_rd_data),
    .pop_i     (unp_pop),
    .row_o     (unp_row),
    .acc_cnt_o (acc_cnt)
  );

  // Load sequencer with registered handshake, status and kernel write outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      count_q   <= '0;
      rows_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q   <= ker_sel;
            count_q <= row_count;
            rows_q  <= '0;
            addr_q  <= base_addr;
            if (row_count == '0) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_REQ;
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (dram_rd_ack) begin
            req_q   <= 1'b0;
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dram_rd_valid) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (unp_pop) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= sel_q;
            wr_addr_q <= rows_q[ROW_ADDR_BITS-1:0];
            wr_data_q <= unp_row;
            rows_q    <= rows_next;
            // Decide the exit on the row being written so no idle cycle is spent.
            if (rows_next == count_q) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
            end else if (acc_cnt < ROW_W2_C) begin
              state_q <= ST_REQ;
              req_q   <= 1'b1;
            end
          end else begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign dram_rd_req  = req_q;
  assign dram_rd_addr = addr_q;
  assign ker_wr_en    = wr_en_q;
  assign ker_wr_sel   = wr_sel_q;
  assign ker_wr_addr  = wr_addr_q;
  assign ker_wr_data  = wr_data_q;

endmodule

// File: tb/tb_kernel_loader.sv
// Scoreboard bench for kernel_loader: a DRAM responder, a monitor popping expected requests/writes.
module tb_kernel_loader;
  import kernel_loader_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   ker_sel = '0;
  logic [28:0]  base_addr = '0;
  logic [11:0]  row_count = '0;
  logic         busy, done, dram_rd_req;
  logic [28:0]  dram_rd_addr;
  logic         dram_rd_ack = 1'b0;
  logic         dram_rd_valid = 1'b0;
  logic [511:0] dram_rd_data = '0;
  logic         ker_wr_en;
  logic [1:0]   ker_wr_sel;
  logic [10:0]  ker_wr_addr;
  logic [74:0]  ker_wr_data;

  always #5 clk = ~clk;

  kernel_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ker_sel(ker_sel), .base_addr(base_addr),
    .row_count(row_count), .busy(busy), .done(done), .dram_rd_req(dram_rd_req),
    .dram_rd_addr(dram_rd_addr), .dram_rd_ack(dram_rd_ack), .dram_rd_valid(dram_rd_valid),
    .dram_rd_data(dram_rd_data), .ker_wr_en(ker_wr_en), .ker_wr_sel(ker_wr_sel),
    .ker_wr_addr(ker_wr_addr), .ker_wr_data(ker_wr_data)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [10:0] addr;
    logic [74:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [28:0] exp_req[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen  = 0;
  int req_seen = 0;
  int max_acc  = 0;
  int ack_dly  = 0;
  int val_dly  = 0;
  logic inject = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] gen_word(input logic [28:0] a, input int w);
    return (32'(a) * 32'h9E37_79B1) ^ (32'(w) * 32'h7F4A_7C15) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [511:0] beat_of(input logic [28:0] a);
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[w*32 +: 32] = gen_word(a, w);
    return b;
  endfunction

  // Row r of the LSB-first bit stream formed by consecutive beats starting at base.
  function automatic logic [74:0] model_row(input logic [28:0] base, input int r);
    logic [74:0] row;
    logic [31:0] wd;
    int k, pos;
    for (int i = 0; i < 75; i++) begin
      k   = r * 75 + i;
      pos = k % 512;
      wd  = gen_word(base + 29'(k / 512), pos / 32);
      row[i] = wd[pos % 32];
    end
    return row;
  endfunction

  task automatic push_load(input logic [1:0] sel, input logic [28:0] base, input int count, input int beats);
    for (int b = 0; b < beats; b++) exp_req.push_back(base + 29'(b));
    for (int r = 0; r < count; r++) exp_wr.push_back({sel, 11'(r), model_row(base, r)});
  endtask

  task automatic do_start(input logic [1:0] sel, input logic [28:0] base, input logic [11:0] count);
    @(negedge clk);
    ker_sel = sel; base_addr = base; row_count = count; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done !== 1'b1) check({name, "_done_timeout"}, 128'(done), 128'(1));
    else check({name, "_busy_at_done"}, 128'(busy), 128'(0));
    @(negedge clk);
    #2;
    check({name, "_done_one_cycle"}, 128'(done), 128'(0));
    check({name, "_reqs_left"}, 128'(exp_req.size()), 128'(0));
    check({name, "_writes_left"}, 128'(exp_wr.size()), 128'(0));
  endtask

  // DRAM responder: configurable ack latency, then one beat after a configurable delay.
  initial begin : dram_model
    int acnt = 0;
    int vcnt = 0;
    bit pend = 0;
    logic [28:0] paddr = '0;
    forever begin
      @(negedge clk);
      dram_rd_ack = 1'b0;
      dram_rd_valid = 1'b0;
      if (!rst_n) begin
        pend = 0;
        acnt = 0;
      end else if (pend) begin
        if (vcnt == 0) begin
          dram_rd_valid = 1'b1;
          dram_rd_data = beat_of(paddr);
          pend = 0;
        end else vcnt--;
      end else if (dram_rd_req) begin
        if (acnt >= ack_dly) begin
          dram_rd_ack = 1'b1;
          paddr = dram_rd_addr;
          pend = 1;
          vcnt = val_dly;
          acnt = 0;
        end else acnt++;
      end
      if (inject) begin
        dram_rd_valid = 1'b1;
        dram_rd_data = {512{1'b1}};
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted request and every kernel write.
  initial begin : monitor
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;
    logic [28:0] prev_addr = '0;
    logic [28:0] ea;
    wr_t ew;
    forever begin
      @(negedge clk);
      #1;
      if (int'(dut.u_unpacker.acc_cnt_o) > max_acc) max_acc = int'(dut.u_unpacker.acc_cnt_o);
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (prev_req && !prev_ack)
          check("req_hold", {98'(dram_rd_req), 29'(dram_rd_addr)}, {98'(1), 29'(prev_addr)});
        if (dram_rd_req && dram_rd_ack) begin
          req_seen++;
          if (exp_req.size() == 0) check("unexpected_req", 128'(dram_rd_addr), 128'h0);
          else begin
            ea = exp_req.pop_front();
            check("req_addr", 128'(dram_rd_addr), 128'(ea));
          end
        end
        if (ker_wr_en) begin
          wr_seen++;
          if (exp_wr.size() == 0)
            check("unexpected_write", 128'({ker_wr_sel, ker_wr_addr}), 128'hFFFF_FFFF);
          else begin
            ew = exp_wr.pop_front();
            check("kernel_write", 128'({ker_wr_sel, ker_wr_addr, ker_wr_data}), 128'(ew));
          end
        end
        prev_req = dram_rd_req;
        prev_ack = dram_rd_ack;
        prev_addr = dram_rd_addr;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [511:0] b0, b1;
    int r0, w0, c;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({busy, done, dram_rd_req, dram_rd_addr, ker_wr_en, ker_wr_sel,
                                ker_wr_addr, ker_wr_data}), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single row.
    r0 = req_seen;
    b0 = beat_of(29'h100);
    exp_req.push_back(29'h100);
    exp_wr.push_back({2'd0, 11'd0, b0[74:0]});
    do_start(2'd0, 29'h100, 12'd1);
    check("t1_busy_after_start", 128'(busy), 128'(1));
    wait_done("t1", 200);
    check("t1_req_count", 128'(req_seen - r0), 128'(1));

    // Row spanning two beats, with an ignored start while busy.
    r0 = req_seen;
    b0 = beat_of(29'h2000);
    b1 = beat_of(29'h2001);
    exp_req.push_back(29'h2000);
    exp_req.push_back(29'h2001);
    for (int r = 0; r < 6; r++) exp_wr.push_back({2'd1, 11'(r), b0[r*75 +: 75]});
    exp_wr.push_back({2'd1, 11'd6, {b1[12:0], b0[511:450]}});
    do_start(2'd1, 29'h2000, 12'd7);
    repeat (2) @(negedge clk);
    ker_sel = 2'd2; base_addr = 29'h5555; row_count = 12'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2", 300);
    check("t2_req_count", 128'(req_seen - r0), 128'(2));

    // Full bank.
    r0 = req_seen;
    w0 = wr_seen;
    push_load(2'd2, 29'h0ABCDE, 1920, 282);
    do_start(2'd2, 29'h0ABCDE, 12'd1920);
    wait_done("t3", 20000);
    check("t3_req_count", 128'(req_seen - r0), 128'(282));
    check("t3_write_count", 128'(wr_seen - w0), 128'(1920));

    // Address wrap without and with handshake stalls; same expected writes.
    for (int s = 0; s < 2; s++) begin
      ack_dly = (s == 0) ? 0 : 5;
      val_dly = (s == 0) ? 0 : 20;
      r0 = req_seen;
      push_load(2'd1, 29'h1FFF_FFFE, 20, 3);
      do_start(2'd1, 29'h1FFF_FFFE, 12'd20);
      wait_done((s == 0) ? "t4_nostall" : "t4_stall", 1000);
      check("t4_req_count", 128'(req_seen - r0), 128'(3));
    end
    ack_dly = 0;
    val_dly = 0;

    // Zero rows: done two cycles after start, no request.
    r0 = req_seen;
    do_start(2'd0, 29'h777, 12'd0);
    check("t5_done_early", 128'({busy, done}), 128'(0));
    @(negedge clk);
    check("t5_done", 128'({busy, done}), 128'(1));
    @(negedge clk);
    check("t5_done_pulse", 128'(done), 128'(0));
    check("t5_no_req", 128'(req_seen - r0), 128'(0));

    // Reset in the middle of a load, then a late beat, then a clean reload.
    w0 = wr_seen;
    push_load(2'd0, 29'h300, 40, 6);
    do_start(2'd0, 29'h300, 12'd40);
    c = 0;
    while ((wr_seen - w0) < 15 && c < 500) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("t6_reached_drain", 128'((wr_seen - w0) >= 15), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", 128'({busy, done, dram_rd_req, dram_rd_addr, ker_wr_en, ker_wr_sel,
                                   ker_wr_addr, ker_wr_data}), 128'(0));
    exp_wr.delete();
    exp_req.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_seen;
    r0 = req_seen;
    @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk);
    #1 inject = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_late_valid_ignored", 128'({busy, 16'(wr_seen - w0), 16'(req_seen - r0)}), 128'(0));
    push_load(2'd0, 29'h300, 40, 6);
    do_start(2'd0, 29'h300, 12'd40);
    wait_done("t6_reload", 1000);

    check("acc_cnt_bound", 128'(max_acc <= 586), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
